// File: rtl/sw_conditioner.sv
// Switch front end for the whack-a-mole game. It synchronises and debounces each slide switch,
// then turns accepted rising edges into a registered hit strobe with the lowest raised index.
module sw_conditioner #(
  parameter int NUM_SW          = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_rise,
  output logic              hit_valid,
  output logic [2:0]        hit_idx,
  output logic              hit_multi
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] r_s1;
  logic [NUM_SW-1:0] r_s2;
  logic [NUM_SW-1:0] r_level;
  logic [NUM_SW-1:0] r_rise;
  logic [CNT_W-1:0]  r_cnt [NUM_SW];
  logic              r_hitValid;
  logic [2:0]        r_hitIdx;
  logic              r_hitMulti;

  logic [NUM_SW-1:0] w_accept;
  logic [2:0]        w_lowIdx;
  logic [3:0]        w_riseCount;
  logic              w_multi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_in;
      r_s2 <= r_s1;
    end
  end

  // A channel is accepted once its synchronised value has disagreed with the level for the full window.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      w_accept[i] = (r_s2[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
      r_rise  <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_rise <= w_accept & r_s2;
      for (int i = 0; i < NUM_SW; i++) begin
        if (r_s2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_level[i] <= r_s2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Descending scan so the lowest set bit is the last one to win.
  always_comb begin
    w_lowIdx    = '0;
    w_riseCount = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (r_rise[i]) begin
        w_lowIdx = 3'(i);
      end
    end
    for (int i = 0; i < NUM_SW; i++) begin
      w_riseCount = w_riseCount + 4'(r_rise[i]);
    end
    w_multi = (w_riseCount >= 4'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hitValid <= 1'b0;
      r_hitIdx   <= '0;
      r_hitMulti <= 1'b0;
    end else begin
      r_hitValid <= |r_rise;
      if (|r_rise) begin
        r_hitIdx   <= w_lowIdx;
        r_hitMulti <= w_multi;
      end else begin
        r_hitMulti <= 1'b0;
      end
    end
  end

  assign sw_level  = r_level;
  assign sw_rise   = r_rise;
  assign hit_valid = r_hitValid;
  assign hit_idx   = r_hitIdx;
  assign hit_multi = r_hitMulti;

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner with a short debounce window of 4 cycles.
// Inputs change 1 time unit after a rising edge, so the next edge is edge 1 of each scenario.
module tb_sw_conditioner;

  localparam int NUM_SW = 5;
  localparam int DEB    = 4;

  logic              clk;
  logic              reset;
  logic [NUM_SW-1:0] sw_in;
  logic [NUM_SW-1:0] sw_level;
  logic [NUM_SW-1:0] sw_rise;
  logic              hit_valid;
  logic [2:0]        hit_idx;
  logic              hit_multi;

  int assertCount = 0;
  int failCount   = 0;

  sw_conditioner #(
    .NUM_SW(NUM_SW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_in(sw_in),
    .sw_level(sw_level),
    .sw_rise(sw_rise),
    .hit_valid(hit_valid),
    .hit_idx(hit_idx),
    .hit_multi(hit_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_SW-1:0] value);
    sw_in = value;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " rise"}, 32'(sw_rise), 32'h0);
    checkOutput({tag, " hit_valid"}, 32'(hit_valid), 32'h0);
    checkOutput({tag, " hit_multi"}, 32'(hit_multi), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(5'b00000);
    #12;
    checkOutput("reset level", 32'(sw_level), 32'h0);
    checkOutput("reset rise", 32'(sw_rise), 32'h0);
    checkOutput("reset hit_valid", 32'(hit_valid), 32'h0);
    checkOutput("reset hit_idx", 32'(hit_idx), 32'h0);
    checkOutput("reset hit_multi", 32'(hit_multi), 32'h0);
    reset = 1'b0;

    // Idle for 50 cycles with every switch low.
    for (int k = 0; k < 50; k++) begin
      waitEdge();
      checkOutput("idle outputs", {22'h0, sw_level, sw_rise, hit_valid, hit_idx, hit_multi}, 32'h0);
    end

    // Single channel rise on switch 3.
    applyStimulus(5'b01000);
    for (int k = 1; k <= 5; k++) begin
      waitEdge();
      checkOutput("sw3 level early", 32'(sw_level), 32'h0);
      checkQuiet("sw3 early");
    end
    waitEdge();
    checkOutput("sw3 level e6", 32'(sw_level), 32'h08);
    checkOutput("sw3 rise e6", 32'(sw_rise), 32'h08);
    checkOutput("sw3 hit_valid e6", 32'(hit_valid), 32'h0);
    waitEdge();
    checkOutput("sw3 rise e7", 32'(sw_rise), 32'h0);
    checkOutput("sw3 hit_valid e7", 32'(hit_valid), 32'h1);
    checkOutput("sw3 hit_idx e7", 32'(hit_idx), 32'h3);
    checkOutput("sw3 hit_multi e7", 32'(hit_multi), 32'h0);
    waitEdge();
    checkOutput("sw3 hit_valid e8", 32'(hit_valid), 32'h0);
    checkOutput("sw3 hit_idx hold", 32'(hit_idx), 32'h3);

    // Bounce on switch 1: high/low pulses of 2 cycles never fill the window.
    for (int b = 0; b < 4; b++) begin
      applyStimulus((b % 2 == 0) ? 5'b01010 : 5'b01000);
      for (int k = 0; k < 2; k++) begin
        waitEdge();
        checkQuiet("bounce");
        checkOutput("bounce level", 32'(sw_level), 32'h08);
      end
    end
    applyStimulus(5'b01010);
    for (int k = 1; k <= 5; k++) begin
      waitEdge();
      checkQuiet("sw1 settle");
      checkOutput("sw1 settle level", 32'(sw_level), 32'h08);
    end
    waitEdge();
    checkOutput("sw1 rise e6", 32'(sw_rise), 32'h02);
    checkOutput("sw1 level e6", 32'(sw_level), 32'h0A);
    waitEdge();
    checkOutput("sw1 rise e7", 32'(sw_rise), 32'h0);
    checkOutput("sw1 hit_valid e7", 32'(hit_valid), 32'h1);
    checkOutput("sw1 hit_idx e7", 32'(hit_idx), 32'h1);
    checkOutput("sw1 hit_multi e7", 32'(hit_multi), 32'h0);
    waitEdge();

    // Switches 0 and 4 rise together.
    applyStimulus(5'b11011);
    for (int k = 1; k <= 5; k++) begin
      waitEdge();
      checkQuiet("dual early");
    end
    waitEdge();
    checkOutput("dual rise e6", 32'(sw_rise), 32'h11);
    checkOutput("dual level e6", 32'(sw_level), 32'h1B);
    waitEdge();
    checkOutput("dual hit_valid e7", 32'(hit_valid), 32'h1);
    checkOutput("dual hit_idx e7", 32'(hit_idx), 32'h0);
    checkOutput("dual hit_multi e7", 32'(hit_multi), 32'h1);
    waitEdge();
    checkOutput("dual hit_valid e8", 32'(hit_valid), 32'h0);
    checkOutput("dual hit_multi e8", 32'(hit_multi), 32'h0);
    checkOutput("dual hit_idx hold", 32'(hit_idx), 32'h0);

    // Switch 2 accepted high, then released.
    applyStimulus(5'b11111);
    for (int k = 0; k < 8; k++) waitEdge();
    checkOutput("sw2 high level", 32'(sw_level), 32'h1F);
    checkOutput("sw2 high hit_idx", 32'(hit_idx), 32'h2);
    applyStimulus(5'b11011);
    for (int k = 1; k <= 8; k++) begin
      waitEdge();
      checkOutput("sw2 fall level", 32'(sw_level), (k < 6) ? 32'h1F : 32'h1B);
      checkQuiet("sw2 fall");
    end

    // Reset three edges into a switch 2 rise; everything clears without a clock edge.
    applyStimulus(5'b11111);
    for (int k = 0; k < 3; k++) begin
      waitEdge();
      checkQuiet("pre-reset");
    end
    reset = 1'b1;
    #2;
    checkOutput("async reset level", 32'(sw_level), 32'h0);
    checkOutput("async reset rise", 32'(sw_rise), 32'h0);
    checkOutput("async reset hit_idx", 32'(hit_idx), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      waitEdge();
      checkQuiet("post-reset early");
      checkOutput("post-reset level", 32'(sw_level), 32'h0);
    end
    waitEdge();
    checkOutput("post-reset rise e6", 32'(sw_rise), 32'h1F);
    checkOutput("post-reset level e6", 32'(sw_level), 32'h1F);
    waitEdge();
    checkOutput("post-reset hit_valid", 32'(hit_valid), 32'h1);
    checkOutput("post-reset hit_idx", 32'(hit_idx), 32'h0);
    checkOutput("post-reset hit_multi", 32'(hit_multi), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
